tbird_light_ctrl: RTL and testbench

- Sequencing controller for the six Thunderbird tail lamps: la/lb/lc on the left, ra/rb/rc on the right.
- Arbitrates between left-turn, right-turn, hazard and brake requests.
- Paces the animation with an internal tick prescaler.
- Sits between the board switches/keys and the lamp LEDs, and drives the lamps directly.

---
 rtl/tbird_light_ctrl.sv | 101 ++++++++++
 tb/tb_tbird_light_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tbird_light_ctrl.sv
// Thunderbird tail-lamp sequencer: turn, hazard and brake arbitration with a
// free-running tick prescaler pacing the animation. All outputs are registered.
module tbird_light_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, HZ_ON, HZ_OFF
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic [5:0]    lamps, lamps_next;
  logic          hz_req;

  always_comb begin
    cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
  end

  // tick is registered from cnt_next so it is high exactly while cnt==DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      tick  <= 1'b0;
      state <= IDLE;
      lamps <= '0;
    end else begin
      cnt   <= cnt_next;
      tick  <= (cnt_next == CNT_MAX);
      state <= next_state;
      lamps <= lamps_next;
    end
  end

  always_comb begin
    next_state = state;
    hz_req     = hazard | (left & right);
    if (tick) begin
      case (state)
        IDLE, HZ_OFF: begin
          if (hz_req)     next_state = HZ_ON;
          else if (left)  next_state = L1;
          else if (right) next_state = R1;
          else            next_state = IDLE;
        end
        L1:      next_state = hz_req ? HZ_ON : L2;
        L2:      next_state = hz_req ? HZ_ON : L3;
        L3:      next_state = hz_req ? HZ_ON : IDLE;
        R1:      next_state = hz_req ? HZ_ON : R2;
        R2:      next_state = hz_req ? HZ_ON : R3;
        R3:      next_state = hz_req ? HZ_ON : IDLE;
        HZ_ON:   next_state = HZ_OFF;
        default: next_state = IDLE;
      endcase
    end
  end

  // Lamps follow next_state so a transition and its pattern land on one edge.
  always_comb begin
    logic [2:0] lpat, rpat;
    logic       lanim, ranim;
    lpat  = '0;
    rpat  = '0;
    lanim = 1'b0;
    ranim = 1'b0;
    case (next_state)
      L1:      begin lpat = 3'b100; lanim = 1'b1; end
      L2:      begin lpat = 3'b110; lanim = 1'b1; end
      L3:      begin lpat = 3'b111; lanim = 1'b1; end
      R1:      begin rpat = 3'b100; ranim = 1'b1; end
      R2:      begin rpat = 3'b110; ranim = 1'b1; end
      R3:      begin rpat = 3'b111; ranim = 1'b1; end
      HZ_ON:   begin lpat = '1; rpat = '1; lanim = 1'b1; ranim = 1'b1; end
      HZ_OFF:  begin lanim = 1'b1; ranim = 1'b1; end
      default: ;
    endcase
    if (brake && !lanim) lpat = '1;
    if (brake && !ranim) rpat = '1;
    lamps_next = {lpat, rpat};
  end

  assign {la, lb, lc, ra, rb, rc} = lamps;

endmodule

// File: tb/tb_tbird_light_ctrl.sv
// Directed bench for tbird_light_ctrl: three instances (DIV=1,2,3) share the
// stimulus; each scenario checks the instance whose DIV it was written for.
module tb_tbird_light_ctrl;

  logic clk = 1'b0;
  logic reset, left, right, hazard, brake;
  logic [5:0] lm1, lm2, lm3;
  logic tk1, tk2, tk3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tbird_light_ctrl #(.DIV(1)) dut1 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .la(lm1[5]), .lb(lm1[4]), .lc(lm1[3]), .ra(lm1[2]), .rb(lm1[1]), .rc(lm1[0]), .tick(tk1));

  tbird_light_ctrl #(.DIV(2)) dut2 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .la(lm2[5]), .lb(lm2[4]), .lc(lm2[3]), .ra(lm2[2]), .rb(lm2[1]), .rc(lm2[0]), .tick(tk2));

  tbird_light_ctrl #(.DIV(3)) dut3 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .la(lm3[5]), .lb(lm3[4]), .lc(lm3[3]), .ra(lm3[2]), .rb(lm3[1]), .rc(lm3[0]), .tick(tk3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b1;
    step();
    step();
    checks++; if (lm1 !== 6'b000000) begin errors++; $display("FAIL reset_lamps_div1 got %b want 000000", lm1); end
    checks++; if (lm2 !== 6'b000000) begin errors++; $display("FAIL reset_lamps_div2 got %b want 000000", lm2); end
    checks++; if (lm3 !== 6'b000000) begin errors++; $display("FAIL reset_lamps_div3 got %b want 000000", lm3); end
    checks++; if (tk1 !== 1'b0) begin errors++; $display("FAIL reset_tick_div1 got %b want 0", tk1); end
    checks++; if (tk2 !== 1'b0) begin errors++; $display("FAIL reset_tick_div2 got %b want 0", tk2); end
    checks++; if (tk3 !== 1'b0) begin errors++; $display("FAIL reset_tick_div3 got %b want 0", tk3); end
    brake = 1'b0;
  endtask

  task automatic test_left_held();
    logic [5:0] exp_l [10];
    exp_l = '{6'b000000, 6'b100000, 6'b100000, 6'b110000, 6'b110000,
              6'b111000, 6'b111000, 6'b000000, 6'b000000, 6'b100000};
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (lm2 !== exp_l[i]) begin
        errors++; $display("FAIL left_held_lamps edge %0d got %b want %b", i + 1, lm2, exp_l[i]);
      end
      checks++;
      if (tk2 !== (i % 2 == 0)) begin
        errors++; $display("FAIL left_held_tick edge %0d got %b want %b", i + 1, tk2, (i % 2 == 0));
      end
    end
    left = 1'b0;
  endtask

  task automatic test_left_pulse();
    logic [5:0] exp_l [10];
    exp_l = '{6'b100000, 6'b110000, 6'b110000, 6'b111000, 6'b111000,
              6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    do_reset();
    left = 1'b1;
    step();
    step();
    checks++;
    if (lm2 !== 6'b100000) begin errors++; $display("FAIL left_pulse_start got %b want 100000", lm2); end
    left = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (lm2 !== exp_l[i]) begin
        errors++; $display("FAIL left_pulse_lamps edge %0d got %b want %b", i + 3, lm2, exp_l[i]);
      end
    end
  endtask

  task automatic test_hazard_both();
    logic found;
    logic [5:0] want;
    do_reset();
    left = 1'b1; right = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      step();
      if (lm1 === 6'b111111) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hazard_both_start got %b want 111111 within 3 cycles", lm1); end
    for (int i = 0; i < 6; i++) begin
      step();
      want = (i % 2 == 0) ? 6'b000000 : 6'b111111;
      checks++;
      if (lm1 !== want) begin
        errors++; $display("FAIL hazard_both_toggle cycle %0d got %b want %b", i, lm1, want);
      end
    end
    left = 1'b0; right = 1'b0;
  endtask

  task automatic test_hazard_abort();
    logic [5:0] exp_r [4];
    exp_r = '{6'b000000, 6'b000100, 6'b000100, 6'b000110};
    do_reset();
    right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (lm2 !== exp_r[i]) begin
        errors++; $display("FAIL hazard_abort_right edge %0d got %b want %b", i + 1, lm2, exp_r[i]);
      end
    end
    hazard = 1'b1;
    step();
    checks++;
    if (lm2 !== 6'b000110) begin errors++; $display("FAIL hazard_abort_hold got %b want 000110", lm2); end
    step();
    checks++;
    if (lm2 !== 6'b111111) begin errors++; $display("FAIL hazard_abort_hzon got %b want 111111", lm2); end
    hazard = 1'b0; right = 1'b0;
    step();
    step();
    checks++;
    if (lm2 !== 6'b000000) begin errors++; $display("FAIL hazard_abort_hzoff got %b want 000000", lm2); end
  endtask

  task automatic test_brake();
    do_reset();
    brake = 1'b1;
    step();
    checks++;
    if (lm3 !== 6'b111111) begin errors++; $display("FAIL brake_idle got %b want 111111", lm3); end
    left = 1'b1;
    step();
    checks++;
    if (lm3 !== 6'b111111) begin errors++; $display("FAIL brake_pretick got %b want 111111", lm3); end
    checks++;
    if (tk3 !== 1'b1) begin errors++; $display("FAIL brake_tick got %b want 1", tk3); end
    step();
    checks++;
    if (lm3 !== 6'b100111) begin errors++; $display("FAIL brake_left got %b want 100111", lm3); end
    brake = 1'b0;
    step();
    checks++;
    if (lm3 !== 6'b100000) begin errors++; $display("FAIL brake_release got %b want 100000", lm3); end
    step();
    step();
    checks++;
    if (lm3 !== 6'b110000) begin errors++; $display("FAIL brake_l2 got %b want 110000", lm3); end
    brake = 1'b1;
    step();
    checks++;
    if (lm3 !== 6'b110111) begin errors++; $display("FAIL brake_in_l2 got %b want 110111", lm3); end
    brake = 1'b0; left = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (lm2 !== 6'b111000) begin errors++; $display("FAIL reset_mid_l3 got %b want 111000", lm2); end
    reset = 1'b1; brake = 1'b1;
    step();
    checks++;
    if (lm2 !== 6'b000000) begin errors++; $display("FAIL reset_mid_lamps got %b want 000000", lm2); end
    reset = 1'b0; brake = 1'b0;
    step();
    checks++;
    if (tk2 !== 1'b1) begin errors++; $display("FAIL reset_mid_first_tick got %b want 1", tk2); end
    checks++;
    if (lm2 !== 6'b000000) begin errors++; $display("FAIL reset_mid_idle got %b want 000000", lm2); end
    step();
    checks++;
    if (lm2 !== 6'b100000) begin errors++; $display("FAIL reset_mid_resume got %b want 100000", lm2); end
    checks++;
    if (tk2 !== 1'b0) begin errors++; $display("FAIL reset_mid_tick_low got %b want 0", tk2); end
    left = 1'b0;
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    test_reset();
    test_left_held();
    test_left_pulse();
    test_hazard_both();
    test_hazard_abort();
    test_brake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
